// File: rtl/cpu19_pkg.sv
// Shared decode constants and enumerations for the 19-bit core's subroutine logic.
package cpu19_pkg;

  localparam logic [1:0] TYPE_JMP = 2'b10;
  localparam logic [3:0] OP_CALL  = 4'b0101;
  localparam logic [3:0] OP_RET   = 4'b0110;

  typedef enum logic [1:0] {
    FLT_NONE = 2'b00,
    FLT_OVF  = 2'b01,
    FLT_UNF  = 2'b10
  } fault_code_e;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } state_e;

endpackage

// File: rtl/subroutine_ctrl_if.sv
// Instruction/redirect bundle between the core execute stage and the subroutine controller.
interface subroutine_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 19,
  parameter int TGT_W = 11
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic [1:0]       types;
  logic [3:0]       opcode;
  logic [TGT_W-1:0] call_addr;
  logic [PC_W-1:0]  pc_current;
  logic             stall;
  logic             program_end;
  logic [PC_W-1:0]  subroutine_pc_next;
  logic             subroutine_pc_src;
  logic [DW-1:0]    stack_depth;
  logic             fault;
  logic [1:0]       fault_code;

  modport master (
    output types, opcode, call_addr, pc_current, stall, program_end,
    input  subroutine_pc_next, subroutine_pc_src, stack_depth, fault, fault_code
  );

  modport slave (
    input  types, opcode, call_addr, pc_current, stall, program_end,
    output subroutine_pc_next, subroutine_pc_src, stack_depth, fault, fault_code
  );
endinterface

// File: rtl/subroutine_ctrl_ras_lifo.sv
// Return-address stack: registered LIFO storage with a saturating occupancy count.
module ras_lifo #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 19
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PC_W-1:0]            push_data,
  output logic [PC_W-1:0]            top,
  output logic [$clog2(DEPTH):0]     depth
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  logic [PC_W-1:0] mem_q [DEPTH];
  logic [PC_W-1:0] mem_d [DEPTH];
  logic [DW-1:0]   depth_q, depth_d;
  logic [AW-1:0]   top_idx;

  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (push && depth_q < FULL) begin
      mem_d[depth_q[AW-1:0]] = push_data;
      depth_d = depth_q + DW'(1);
    end else if (pop && depth_q != '0) begin
      depth_d = depth_q - DW'(1);
    end
  end

  // Storage needs no reset; only the count decides which entries are meaningful.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) depth_q <= '0;
    else        depth_q <= depth_d;
  end

  assign top_idx = depth_q[AW-1:0] - AW'(1);
  assign top     = mem_q[top_idx];
  assign depth   = depth_q;

  a_no_push_pop : assert property (@(posedge clk) disable iff (!rst_n) !(push && pop));

endmodule

// File: rtl/subroutine_ctrl.sv
// CALL/RET sequencer: decodes the execute-stage instruction, drives the redirect and manages the RAS.
//  state   | meaning
//  S_RUN   | normal operation, CALL pushes / RET pops the return-address stack
//  S_FAULT | overflow or underflow seen; core held at current PC until reset
module subroutine_ctrl
  import cpu19_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = 19,
  parameter int TGT_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  subroutine_ctrl_if.slave  bus
);
  localparam int DW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  state_e          state_q, state_d;
  fault_code_e     fault_code_q, fault_code_d;
  logic            fault_q, fault_d;

  logic            is_call, is_ret, active;
  logic            push, pop;
  logic [PC_W-1:0] pc_inc, ras_top, next_pc;
  logic            pc_src;
  logic [DW-1:0]   depth;

  assign is_call = (bus.types == TYPE_JMP) && (bus.opcode == OP_CALL);
  assign is_ret  = (bus.types == TYPE_JMP) && (bus.opcode == OP_RET);
  assign active  = !bus.stall && !bus.program_end;
  assign pc_inc  = bus.pc_current + PC_W'(1);

  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    push         = 1'b0;
    pop          = 1'b0;
    pc_src       = 1'b0;
    next_pc      = pc_inc;
    case (state_q)
      S_RUN: begin
        // program_end lets the branch unit hold the PC; nothing is redirected.
        if (!bus.program_end) begin
          if (is_call) begin
            pc_src = 1'b1;
            if (depth == FULL) begin
              next_pc = bus.pc_current;
              if (active) begin
                state_d      = S_FAULT;
                fault_code_d = FLT_OVF;
              end
            end else begin
              next_pc = PC_W'(bus.call_addr);
              push    = active;
            end
          end else if (is_ret) begin
            pc_src = 1'b1;
            if (depth == '0) begin
              next_pc = bus.pc_current;
              if (active) begin
                state_d      = S_FAULT;
                fault_code_d = FLT_UNF;
              end
            end else begin
              next_pc = ras_top;
              pop     = active;
            end
          end
        end
      end
      S_FAULT: begin
        pc_src  = 1'b1;
        next_pc = bus.pc_current;
      end
      default: state_d = S_FAULT;
    endcase
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      fault_code_q <= FLT_NONE;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
      fault_q      <= fault_d;
    end
  end

  ras_lifo #(.DEPTH(DEPTH), .PC_W(PC_W)) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .depth     (depth)
  );

  assign bus.subroutine_pc_next = next_pc;
  assign bus.subroutine_pc_src  = pc_src;
  assign bus.stack_depth        = depth;
  assign bus.fault              = fault_q;
  assign bus.fault_code         = fault_code_q;

endmodule

// File: tb/tb_subroutine_ctrl.sv
// Scoreboard bench for subroutine_ctrl: directed vectors push expectations, a negedge monitor checks them.
module tb_subroutine_ctrl;

  localparam int DEPTH = 8;
  localparam int PC_W  = 19;
  localparam int TGT_W = 11;

  typedef struct {
    string        name;
    logic         src;
    logic [18:0]  next;
    logic [3:0]   depth;
    logic         fault;
    logic [1:0]   code;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  subroutine_ctrl_if #(.DEPTH(DEPTH), .PC_W(PC_W), .TGT_W(TGT_W)) bus();

  subroutine_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W), .TGT_W(TGT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".src"},   32'(bus.subroutine_pc_src), 32'(e.src));
      check({e.name, ".next"},  32'(bus.subroutine_pc_next), 32'(e.next));
      check({e.name, ".depth"}, 32'(bus.stack_depth), 32'(e.depth));
      check({e.name, ".fault"}, 32'(bus.fault), 32'(e.fault));
      check({e.name, ".code"},  32'(bus.fault_code), 32'(e.code));
    end
  end

  // Drive one instruction for one cycle and queue the outputs expected during that cycle.
  task automatic step(input string name, input logic [1:0] ty, input logic [3:0] op,
                      input logic [10:0] addr, input logic [18:0] pc, input logic st,
                      input logic pe, input logic e_src, input logic [18:0] e_next,
                      input logic [3:0] e_depth, input logic e_fault, input logic [1:0] e_code);
    exp_t e;
    bus.types = ty; bus.opcode = op; bus.call_addr = addr;
    bus.pc_current = pc; bus.stall = st; bus.program_end = pe;
    e.name = name; e.src = e_src; e.next = e_next; e.depth = e_depth;
    e.fault = e_fault; e.code = e_code;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input string name, input logic [18:0] pc, input logic e_src,
                      input logic [18:0] e_next, input logic [3:0] d, input logic f,
                      input logic [1:0] c);
    step(name, 2'b00, 4'h0, 11'h0, pc, 1'b0, 1'b0, e_src, e_next, d, f, c);
  endtask

  task automatic do_reset();
    bus.types = 2'b00; bus.opcode = 4'h0; bus.call_addr = '0;
    bus.pc_current = '0; bus.stall = 1'b0; bus.program_end = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int wait_cycles;
    @(posedge clk); #1;
    do_reset();

    idle("rst", 19'h5, 1'b0, 19'h6, 4'd0, 1'b0, 2'b00);
    idle("wrap_inc", 19'h7FFFF, 1'b0, 19'h0, 4'd0, 1'b0, 2'b00);
    step("call1", 2'b10, 4'h5, 11'h040, 19'h10, 1'b0, 1'b0, 1'b1, 19'h40, 4'd0, 1'b0, 2'b00);
    idle("after_call1", 19'h40, 1'b0, 19'h41, 4'd1, 1'b0, 2'b00);
    step("ret1", 2'b10, 4'h6, 11'h0, 19'h45, 1'b0, 1'b0, 1'b1, 19'h11, 4'd1, 1'b0, 2'b00);
    idle("after_ret1", 19'h11, 1'b0, 19'h12, 4'd0, 1'b0, 2'b00);
    step("wrong_type", 2'b01, 4'h5, 11'h040, 19'h12, 1'b0, 1'b0, 1'b0, 19'h13, 4'd0, 1'b0, 2'b00);

    for (int i = 1; i <= 8; i++)
      step($sformatf("nest_call%0d", i), 2'b10, 4'h5, 11'(11'h100 + i), 19'(i), 1'b0, 1'b0,
           1'b1, 19'(19'h100 + i), 4'(i - 1), 1'b0, 2'b00);
    for (int k = 0; k < 8; k++)
      step($sformatf("nest_ret%0d", k), 2'b10, 4'h6, 11'h0, 19'h200, 1'b0, 1'b0,
           1'b1, 19'(9 - k), 4'(8 - k), 1'b0, 2'b00);
    idle("nest_done", 19'h2, 1'b0, 19'h3, 4'd0, 1'b0, 2'b00);

    for (int i = 1; i <= 8; i++)
      step($sformatf("fill%0d", i), 2'b10, 4'h5, 11'h300, 19'(19'h30 + i), 1'b0, 1'b0,
           1'b1, 19'h300, 4'(i - 1), 1'b0, 2'b00);
    step("full_call_stall", 2'b10, 4'h5, 11'h055, 19'h20, 1'b1, 1'b0, 1'b1, 19'h20, 4'd8, 1'b0, 2'b00);
    step("ovf_call", 2'b10, 4'h5, 11'h055, 19'h20, 1'b0, 1'b0, 1'b1, 19'h20, 4'd8, 1'b0, 2'b00);
    step("ovf_ret", 2'b10, 4'h6, 11'h0, 19'h33, 1'b0, 1'b0, 1'b1, 19'h33, 4'd8, 1'b1, 2'b01);
    idle("ovf_hold", 19'h34, 1'b1, 19'h34, 4'd8, 1'b1, 2'b01);
    do_reset();
    idle("ovf_cleared", 19'h9, 1'b0, 19'hA, 4'd0, 1'b0, 2'b00);

    step("unf_stall", 2'b10, 4'h6, 11'h0, 19'h3, 1'b1, 1'b0, 1'b1, 19'h3, 4'd0, 1'b0, 2'b00);
    idle("unf_stall_nofault", 19'h3, 1'b0, 19'h4, 4'd0, 1'b0, 2'b00);
    step("unf_ret", 2'b10, 4'h6, 11'h0, 19'h7, 1'b0, 1'b0, 1'b1, 19'h7, 4'd0, 1'b0, 2'b00);
    idle("unf_hold", 19'h8, 1'b1, 19'h8, 4'd0, 1'b1, 2'b10);
    step("unf_call_hold", 2'b10, 4'h5, 11'h040, 19'h9, 1'b0, 1'b0, 1'b1, 19'h9, 4'd0, 1'b1, 2'b10);
    do_reset();

    for (int s = 0; s < 3; s++)
      step($sformatf("stall_call%0d", s), 2'b10, 4'h5, 11'h060, 19'h50, 1'b1, 1'b0,
           1'b1, 19'h60, 4'd0, 1'b0, 2'b00);
    step("stall_release", 2'b10, 4'h5, 11'h060, 19'h50, 1'b0, 1'b0, 1'b1, 19'h60, 4'd0, 1'b0, 2'b00);
    idle("stall_once", 19'h60, 1'b0, 19'h61, 4'd1, 1'b0, 2'b00);
    step("stall_ret", 2'b10, 4'h6, 11'h0, 19'h61, 1'b0, 1'b0, 1'b1, 19'h51, 4'd1, 1'b0, 2'b00);
    idle("stall_ret_done", 19'h51, 1'b0, 19'h52, 4'd0, 1'b0, 2'b00);

    step("pend_call", 2'b10, 4'h5, 11'h080, 19'h70, 1'b0, 1'b1, 1'b0, 19'h71, 4'd0, 1'b0, 2'b00);
    idle("pend_nopush", 19'h70, 1'b0, 19'h71, 4'd0, 1'b0, 2'b00);
    step("wrap_call", 2'b10, 4'h5, 11'h010, 19'h7FFFF, 1'b0, 1'b0, 1'b1, 19'h10, 4'd0, 1'b0, 2'b00);
    idle("wrap_pushed", 19'h10, 1'b0, 19'h11, 4'd1, 1'b0, 2'b00);
    step("wrap_ret", 2'b10, 4'h6, 11'h0, 19'h12, 1'b0, 1'b0, 1'b1, 19'h0, 4'd1, 1'b0, 2'b00);
    idle("wrap_done", 19'h0, 1'b0, 19'h1, 4'd0, 1'b0, 2'b00);

    // Reset asserted on the same edge that would retire a CALL.
    bus.types = 2'b10; bus.opcode = 4'h5; bus.call_addr = 11'h022;
    bus.pc_current = 19'h40; bus.stall = 1'b0; bus.program_end = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle("rst_mid_call", 19'h40, 1'b0, 19'h41, 4'd0, 1'b0, 2'b00);

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
